square_wave_param_ctrl: RTL and testbench



---
 rtl/square_wave_pkg.sv | 17 +
 rtl/square_wave_param_ctrl_debounce.sv | 44 ++++
 rtl/square_wave_param_ctrl.sv | 95 +++++++++
 tb/tb_square_wave_param_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/square_wave_pkg.sv
// Shared types and default waveform parameters for the square-wave VGA
// controller and pixel generator.
package square_wave_pkg;

  typedef enum logic {SEL_HIGH = 1'b0, SEL_LOW = 1'b1} sel_t;

  localparam int KEY_SEL = 0;
  localparam int KEY_INC = 1;
  localparam int KEY_DEC = 2;

  localparam int DEF_LEN_W       = 7;
  localparam int DEF_LEN_MIN     = 4;
  localparam int DEF_LEN_MAX     = 64;
  localparam int DEF_LEN_STEP    = 4;
  localparam int DEF_LEN_DEFAULT = 16;

endpackage

// File: rtl/square_wave_param_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and a one-cycle pulse on each accepted press (1->0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Flip happens on the edge that would make the count reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync  <= 2'b11;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb   <= r_sync[1];
        r_cnt   <= '0;
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/square_wave_param_ctrl.sv
// Key-driven editor for the square-wave high/low phase lengths; edits go to
// shadow registers and are committed to the live outputs on frame_tick.
module square_wave_param_ctrl
  import square_wave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int LEN_W           = DEF_LEN_W,
  parameter int LEN_MIN         = DEF_LEN_MIN,
  parameter int LEN_MAX         = DEF_LEN_MAX,
  parameter int LEN_STEP        = DEF_LEN_STEP,
  parameter int LEN_DEFAULT     = DEF_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       key,
  input  logic             frame_tick,
  output logic [LEN_W-1:0] high_len,
  output logic [LEN_W-1:0] low_len,
  output logic             sel_field,
  output logic             update_pending
);

  localparam logic [LEN_W:0]   L_MAX   = (LEN_W+1)'(LEN_MAX);
  localparam logic [LEN_W:0]   L_FLOOR = (LEN_W+1)'(LEN_MIN + LEN_STEP);
  localparam logic [LEN_W:0]   L_STEP  = (LEN_W+1)'(LEN_STEP);
  localparam logic [LEN_W-1:0] L_DEF   = LEN_W'(LEN_DEFAULT);

  logic [2:0] w_press;

  for (genvar g = 0; g < 3; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (key[g]),
      .press   (w_press[g])
    );
  end

  sel_t r_state, w_state_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= SEL_HIGH;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_press[KEY_SEL]) w_state_nxt = (r_state == SEL_HIGH) ? SEL_LOW : SEL_HIGH;
  end

  always_comb sel_field = (r_state == SEL_LOW);

  logic [LEN_W-1:0] r_sh_hi, r_sh_lo, r_hi, r_lo;
  logic             r_pend;
  logic [LEN_W-1:0] w_cur, w_edit, w_sh_hi_nxt, w_sh_lo_nxt, w_hi_nxt, w_lo_nxt;
  logic [LEN_W:0]   w_up, w_dn;
  logic             w_inc, w_dec;

  // Simultaneous inc+dec cancel; edits target the field selected before any toggle.
  always_comb begin
    w_inc  = w_press[KEY_INC] & ~w_press[KEY_DEC];
    w_dec  = w_press[KEY_DEC] & ~w_press[KEY_INC];
    w_cur  = (r_state == SEL_HIGH) ? r_sh_hi : r_sh_lo;
    w_up   = {1'b0, w_cur} + L_STEP;
    w_dn   = {1'b0, w_cur} - L_STEP;
    w_edit = w_cur;
    if (w_inc) w_edit = (w_up > L_MAX) ? LEN_W'(LEN_MAX) : w_up[LEN_W-1:0];
    if (w_dec) w_edit = ({1'b0, w_cur} < L_FLOOR) ? LEN_W'(LEN_MIN) : w_dn[LEN_W-1:0];
    w_sh_hi_nxt = (r_state == SEL_HIGH) ? w_edit : r_sh_hi;
    w_sh_lo_nxt = (r_state == SEL_LOW)  ? w_edit : r_sh_lo;
    w_hi_nxt    = frame_tick ? r_sh_hi : r_hi;
    w_lo_nxt    = frame_tick ? r_sh_lo : r_lo;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sh_hi <= L_DEF;
      r_sh_lo <= L_DEF;
      r_hi    <= L_DEF;
      r_lo    <= L_DEF;
      r_pend  <= 1'b0;
    end else begin
      r_sh_hi <= w_sh_hi_nxt;
      r_sh_lo <= w_sh_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_pend  <= (w_sh_hi_nxt != w_hi_nxt) || (w_sh_lo_nxt != w_lo_nxt);
    end
  end

  assign high_len       = r_hi;
  assign low_len        = r_lo;
  assign update_pending = r_pend;

endmodule

// File: tb/tb_square_wave_param_ctrl.sv
// Directed bench for square_wave_param_ctrl: stimulus pushes expected outputs
// into a queue, a negedge monitor pops and compares on each check request.
module tb_square_wave_param_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] key = 3'b111;
  logic       frame_tick = 1'b0;
  logic [6:0] high_len, low_len;
  logic       sel_field, update_pending;

  always #5 clk = ~clk;

  square_wave_param_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key            (key),
    .frame_tick     (frame_tick),
    .high_len       (high_len),
    .low_len        (low_len),
    .sel_field      (sel_field),
    .update_pending (update_pending)
  );

  typedef struct packed {
    logic [6:0] hi;
    logic [6:0] lo;
    logic       sel;
    logic       pend;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  m_exp;
  string m_name;
  logic  chk_req = 1'b0;
  int    n_cmp = 0;
  int    n_err = 0;

  always @(negedge clk) begin
    if (chk_req) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL no_expect: monitor asked to compare with empty queue");
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        if ({high_len, low_len, sel_field, update_pending} !== m_exp) begin
          n_err++;
          $display("FAIL %s: got hi=%0d lo=%0d sel=%0d pend=%0d, want hi=%0d lo=%0d sel=%0d pend=%0d",
                   m_name, high_len, low_len, sel_field, update_pending,
                   m_exp.hi, m_exp.lo, m_exp.sel, m_exp.pend);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int hi, input int lo, input bit sel, input bit pend);
    exp_t e;
    e.hi = 7'(hi); e.lo = 7'(lo); e.sel = sel; e.pend = pend;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic press(input logic [2:0] mask);
    key = ~mask;
    cyc(10);
    key = 3'b111;
    cyc(10);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, and reset in the middle of a debounce
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    check("reset", 16, 16, 0, 0);
    key[1] = 1'b0;
    cyc(5);
    reset_n = 1'b0;
    cyc(1);
    key[1] = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(15);
    check("rst_mid_debounce", 16, 16, 0, 0);

    // 2: press latency and frame commit
    key[1] = 1'b0;
    cyc(6);
    check("inc_before_lat", 16, 16, 0, 0);
    cyc(1);
    check("inc_at_lat", 16, 16, 0, 1);
    cyc(3);
    key = 3'b111;
    cyc(10);
    check("inc_held_no_tick", 16, 16, 0, 1);
    tick();
    check("commit_high20", 20, 16, 0, 0);

    // 3: glitch rejection, field toggle, low-side saturation
    key[2] = 1'b0;
    cyc(3);
    key = 3'b111;
    cyc(10);
    check("glitch_ignored", 20, 16, 0, 0);
    press(3'b001);
    check("toggle_to_low", 20, 16, 1, 0);
    repeat (3) press(3'b100);
    check("dec_low_x3", 20, 16, 1, 1);
    tick();
    check("commit_low4", 20, 4, 1, 0);
    press(3'b100);
    check("dec_sat_min", 20, 4, 1, 0);

    // 4: high-side saturation
    press(3'b001);
    check("toggle_to_high", 20, 4, 0, 0);
    for (int i = 0; i < 15; i++) press(3'b010);
    check("inc_x15_pending", 20, 4, 0, 1);
    tick();
    check("inc_sat_max", 64, 4, 0, 0);

    // 5: coincident key presses
    press(3'b110);
    check("inc_dec_cancel", 64, 4, 0, 0);
    press(3'b100);
    check("dec_high60", 64, 4, 0, 1);
    tick();
    check("commit_high60", 60, 4, 0, 0);
    press(3'b011);
    check("sel_plus_inc", 60, 4, 1, 1);
    tick();
    check("commit_sel_inc", 64, 4, 1, 0);

    // 6: press pulse in the same cycle as frame_tick
    key[1] = 1'b0;
    cyc(6);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check("inc_at_tick", 64, 4, 1, 1);
    cyc(3);
    key = 3'b111;
    cyc(10);
    tick();
    check("commit_next_tick", 64, 8, 1, 0);

    cyc(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
